// File: rtl/ram_mbist_ctrl.sv
// March C- BIST sequencer for a single-port RAM: drives every address through six march
// elements, checks read data through a latency-matched compare pipe and keeps first-fail data.
module ram_mbist_ctrl #(
   parameter int                ADDR_W = 6,
   parameter int                DATA_W = 8,
   parameter int                RD_LAT = 1,
   parameter logic [DATA_W-1:0] BG     = '0
) (
   input  logic              CoreIN_CLK,
   input  logic              CoreIN_RESET,
   input  logic              bist_start,
   output logic              bist_busy,
   output logic              bist_done,
   output logic              bist_fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_elem,
   output logic [DATA_W-1:0] fail_bits,
   output logic [7:0]        err_cnt,
   output logic              ram_rx,
   output logic              ram_tx,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [3:0] {
      M0 = 4'd0, M1 = 4'd1, M2 = 4'd2, M3 = 4'd3, M4 = 4'd4, M5 = 4'd5,
      IDLE = 4'd8, DRAIN = 4'd9, DONE = 4'd10
   } stateT;

   typedef struct packed {
      stateT             elem;
      logic              ph;
      logic [ADDR_W-1:0] addr;
   } posT;

   typedef struct packed {
      logic              rx;
      logic              tx;
      logic [DATA_W-1:0] din;
   } opT;

   typedef struct packed {
      logic [DATA_W-1:0] exp;
      logic [ADDR_W-1:0] addr;
      logic [2:0]        elem;
   } cmpT;

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [DATA_W-1:0] PAT_D    = BG;
   localparam logic [DATA_W-1:0] PAT_N    = ~BG;
   localparam int                DRN_W    = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
   localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(RD_LAT - 1);

   // Position of the op after (s, ph, a); elements M1..M4 read then write each address.
   function automatic posT nextPos(stateT s, logic ph, logic [ADDR_W-1:0] a);
      posT  n;
      logic up;
      logic last;
      n.elem = s;
      n.ph   = 1'b0;
      n.addr = a;
      up     = (s == M0) || (s == M1) || (s == M2) || (s == M5);
      last   = up ? (a == ADDR_MAX) : (a == '0);
      if (!ph && (s inside {M1, M2, M3, M4})) begin
         n.ph = 1'b1;
      end else if (!last) begin
         n.addr = up ? a + 1'b1 : a - 1'b1;
      end else begin
         case (s)
            M0:      begin n.elem = M1;    n.addr = '0;       end
            M1:      begin n.elem = M2;    n.addr = '0;       end
            M2:      begin n.elem = M3;    n.addr = ADDR_MAX; end
            M3:      begin n.elem = M4;    n.addr = ADDR_MAX; end
            M4:      begin n.elem = M5;    n.addr = '0;       end
            default: begin n.elem = DRAIN; n.addr = '0;       end
         endcase
      end
      return n;
   endfunction

   function automatic opT opFor(stateT s, logic ph);
      opT   o;
      logic dual;
      dual  = s inside {M1, M2, M3, M4};
      o.rx  = (s == M5) || (dual && !ph);
      o.tx  = (s == M0) || (dual && ph);
      o.din = o.tx ? (((s == M1) || (s == M3)) ? PAT_N : PAT_D) : '0;
      return o;
   endfunction

   function automatic logic [DATA_W-1:0] expOf(stateT s);
      return ((s == M2) || (s == M4)) ? PAT_N : PAT_D;
   endfunction

   function automatic logic [7:0] satInc(logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   stateT             state;
   logic              ph;
   logic [DRN_W-1:0]  drainCnt;
   posT               nxt;
   opT                nxtOp;
   logic [RD_LAT-1:0] vld_p;
   cmpT               cmp_p [RD_LAT];
   cmpT               cmpTail;
   logic              mism;

   assign nxt     = nextPos(state, ph, ram_addr);
   assign nxtOp   = opFor(nxt.elem, nxt.ph);
   assign cmpTail = cmp_p[RD_LAT-1];
   assign mism    = vld_p[RD_LAT-1] && (ram_dout != cmpTail.exp);

   // Compare pipe: stage 0 captures the read being driven, the tail lines up with ram_dout.
   always_ff @(posedge CoreIN_CLK or negedge CoreIN_RESET) begin
      if (!CoreIN_RESET) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= ram_rx;
         for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge CoreIN_CLK) begin
      cmp_p[0] <= {expOf(state), ram_addr, state[2:0]};
      for (int i = 1; i < RD_LAT; i++) cmp_p[i] <= cmp_p[i-1];
   end

   // Sequencer: state/ph/ram_addr always describe the op currently on the RAM pins.
   always_ff @(posedge CoreIN_CLK or negedge CoreIN_RESET) begin
      if (!CoreIN_RESET) begin
         state     <= IDLE;
         ph        <= 1'b0;
         drainCnt  <= '0;
         bist_busy <= 1'b0;
         bist_done <= 1'b0;
         bist_fail <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
         fail_bits <= '0;
         err_cnt   <= '0;
         ram_rx    <= 1'b0;
         ram_tx    <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bist_start) begin
                  state     <= M0;
                  ph        <= 1'b0;
                  ram_rx    <= 1'b0;
                  ram_tx    <= 1'b1;
                  ram_addr  <= '0;
                  ram_din   <= PAT_D;
                  bist_busy <= 1'b1;
                  bist_done <= 1'b0;
                  bist_fail <= 1'b0;
                  fail_addr <= '0;
                  fail_elem <= '0;
                  fail_bits <= '0;
                  err_cnt   <= '0;
               end
            end
            DRAIN: begin
               if (drainCnt == DRN_LAST) begin
                  state     <= DONE;
                  bist_busy <= 1'b0;
                  bist_done <= 1'b1;
               end else begin
                  drainCnt <= drainCnt + 1'b1;
               end
            end
            default: begin
               state <= nxt.elem;
               ph    <= nxt.ph;
               if (nxt.elem == DRAIN) begin
                  ram_rx   <= 1'b0;
                  ram_tx   <= 1'b0;
                  ram_addr <= '0;
                  ram_din  <= '0;
                  drainCnt <= '0;
               end else begin
                  ram_rx   <= nxtOp.rx;
                  ram_tx   <= nxtOp.tx;
                  ram_addr <= nxt.addr;
                  ram_din  <= nxtOp.din;
               end
            end
         endcase
         if (mism) begin
            err_cnt <= satInc(err_cnt);
            if (!bist_fail) begin
               bist_fail <= 1'b1;
               fail_addr <= cmpTail.addr;
               fail_elem <= cmpTail.elem;
               fail_bits <= ram_dout ^ cmpTail.exp;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_mbist_ctrl.sv
// Bench for ram_mbist_ctrl: two instances (RD_LAT 1 and 2) on behavioural RAMs with an
// injectable stuck-at cell, driven by directed runs with hand-computed timing and diagnostics.
module tb_ram_mbist_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic bist_start;
   always #5 clk = ~clk;

   logic       busyS [2];
   logic       doneS [2];
   logic       failS [2];
   logic       rxS   [2];
   logic       txS   [2];
   logic [5:0] fAddrS[2];
   logic [5:0] addrS [2];
   logic [2:0] fElemS[2];
   logic [7:0] fBitsS[2];
   logic [7:0] errS  [2];
   logic [7:0] dinS  [2];
   logic [7:0] dout0, dout1, stage1;
   logic [7:0] mem0 [64];
   logic [7:0] mem1 [64];

   logic       faultOn;
   logic [5:0] faultAddr;
   logic [7:0] sa1, sa0;
   int coll0 = 0;
   int coll1 = 0;
   int nPass = 0;
   int nChecks = 0;

   ram_mbist_ctrl #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1), .BG(8'h00)) u1 (
      .CoreIN_CLK(clk), .CoreIN_RESET(rst_n), .bist_start(bist_start),
      .bist_busy(busyS[0]), .bist_done(doneS[0]), .bist_fail(failS[0]),
      .fail_addr(fAddrS[0]), .fail_elem(fElemS[0]), .fail_bits(fBitsS[0]), .err_cnt(errS[0]),
      .ram_rx(rxS[0]), .ram_tx(txS[0]), .ram_addr(addrS[0]), .ram_din(dinS[0]), .ram_dout(dout0)
   );

   ram_mbist_ctrl #(.ADDR_W(6), .DATA_W(8), .RD_LAT(2), .BG(8'h00)) u2 (
      .CoreIN_CLK(clk), .CoreIN_RESET(rst_n), .bist_start(bist_start),
      .bist_busy(busyS[1]), .bist_done(doneS[1]), .bist_fail(failS[1]),
      .fail_addr(fAddrS[1]), .fail_elem(fElemS[1]), .fail_bits(fBitsS[1]), .err_cnt(errS[1]),
      .ram_rx(rxS[1]), .ram_tx(txS[1]), .ram_addr(addrS[1]), .ram_din(dinS[1]), .ram_dout(dout1)
   );

   function automatic logic [7:0] stored(logic [5:0] a, logic [7:0] d);
      if (faultOn && a == faultAddr) return (d | sa1) & ~sa0;
      return d;
   endfunction

   // RAM models: one-cycle and two-cycle read latency, sharing the same fault cell.
   always @(posedge clk) begin
      if (txS[0]) mem0[addrS[0]] <= stored(addrS[0], dinS[0]);
      if (rxS[0]) dout0 <= mem0[addrS[0]];
      if (txS[1]) mem1[addrS[1]] <= stored(addrS[1], dinS[1]);
      if (rxS[1]) stage1 <= mem1[addrS[1]];
      dout1 <= stage1;
      if (rxS[0] && txS[0]) coll0 <= coll0 + 1;
      if (rxS[1] && txS[1]) coll1 <= coll1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic setFault(input logic on, input logic [5:0] a, input logic [7:0] s1, input logic [7:0] s0);
      faultOn = on; faultAddr = a; sa1 = s1; sa0 = s0;
   endtask

   task automatic idleZero(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s.status%0d", tag, d),
             {busyS[d], doneS[d], failS[d], fAddrS[d], fElemS[d], fBitsS[d], errS[d]}, 32'd0);
         chk($sformatf("%s.ram%0d", tag, d), {rxS[d], txS[d], addrS[d], dinS[d]}, 32'd0);
      end
   endtask

   // One start pulse, then follow both instances to DONE and check timing and diagnostics.
   task automatic runCheck(input string tag, input logic expFail, input logic [2:0] expElem,
                           input logic [5:0] expAddr, input logic [7:0] expBits, input logic [7:0] expErr);
      int doneAt[2];
      int busyCnt[2];
      doneAt  = '{0, 0};
      busyCnt = '{0, 0};
      @(negedge clk); bist_start = 1'b1;
      @(negedge clk); bist_start = 1'b0;
      for (int k = 1; k <= 700; k++) begin
         if (k > 1) @(negedge clk);
         if (k == 1)  chk($sformatf("%s.op1", tag),  {txS[0], rxS[0], addrS[0], dinS[0]}, {1'b1, 1'b0, 6'd0, 8'h00});
         if (k == 65) chk($sformatf("%s.op65", tag), {txS[0], rxS[0], addrS[0]}, {1'b0, 1'b1, 6'd0});
         if (k == 66) chk($sformatf("%s.op66", tag), {txS[0], rxS[0], addrS[0], dinS[0]}, {1'b1, 1'b0, 6'd0, 8'hFF});
         for (int d = 0; d < 2; d++) begin
            if (busyS[d]) busyCnt[d]++;
            if (doneS[d] && doneAt[d] == 0) doneAt[d] = k;
         end
         if (doneAt[0] != 0 && doneAt[1] != 0) break;
      end
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s.doneAt%0d", tag, d), doneAt[d], 642 + d);
         chk($sformatf("%s.busyCycles%0d", tag, d), busyCnt[d], 641 + d);
         chk($sformatf("%s.fail%0d", tag, d), failS[d], expFail);
         chk($sformatf("%s.diag%0d", tag, d), {fElemS[d], fAddrS[d], fBitsS[d]}, {expElem, expAddr, expBits});
         chk($sformatf("%s.errCnt%0d", tag, d), errS[d], expErr);
         chk($sformatf("%s.ramIdle%0d", tag, d), {rxS[d], txS[d], addrS[d], dinS[d]}, 32'd0);
      end
      chk($sformatf("%s.rxtxOverlap", tag), coll0 + coll1, 0);
   endtask

   // Start held high: ignored while running, re-accepted once in DONE.
   task automatic heldStart();
      int first[2];
      int second[2];
      first  = '{0, 0};
      second = '{0, 0};
      @(negedge clk); bist_start = 1'b1;
      for (int k = 1; k <= 1400; k++) begin
         @(negedge clk);
         if (k == 2) chk("held.noRestart", {busyS[0], busyS[1], addrS[0], addrS[1]}, {1'b1, 1'b1, 6'd1, 6'd1});
         for (int d = 0; d < 2; d++) begin
            if (first[d] != 0 && k == first[d] + 1)
               chk($sformatf("held.reaccept%0d", d), {doneS[d], busyS[d], failS[d], errS[d]}, {1'b0, 1'b1, 1'b0, 8'd0});
            if (first[d] != 0 && k > first[d] + 1 && doneS[d] && second[d] == 0) second[d] = k;
            if (doneS[d] && first[d] == 0) begin
               first[d] = k;
               chk($sformatf("held.firstDiag%0d", d), {failS[d], fElemS[d], errS[d]}, {1'b1, 3'd2, 8'd2});
            end
         end
         if (k == 644) bist_start = 1'b0;
         if (second[0] != 0 && second[1] != 0) break;
      end
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("held.firstDone%0d", d), first[d], 642 + d);
         chk($sformatf("held.secondDone%0d", d), second[d], 1284 + 2 * d);
         chk($sformatf("held.secondDiag%0d", d), {failS[d], fAddrS[d], fBitsS[d], errS[d]},
             {1'b1, 6'h3F, 8'h80, 8'd2});
      end
   endtask

   // Reset asserted in the middle of M2 (op 250 = M2 write of address 28).
   task automatic midReset();
      setFault(1'b1, 6'h2A, 8'h01, 8'h00);
      @(negedge clk); bist_start = 1'b1;
      @(negedge clk); bist_start = 1'b0;
      repeat (249) @(negedge clk);
      chk("mid.inM2", {failS[0], txS[0], rxS[0], addrS[0], dinS[0]}, {1'b1, 1'b1, 1'b0, 6'd28, 8'h00});
      rst_n = 1'b0;
      #1;
      idleZero("midReset");
      @(negedge clk); rst_n = 1'b1;
      setFault(1'b0, 6'h00, 8'h00, 8'h00);
      runCheck("rerun", 1'b0, 3'd0, 6'h00, 8'h00, 8'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      bist_start = 1'b0;
      setFault(1'b0, 6'h00, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      idleZero("reset");
      rst_n = 1'b1;
      runCheck("clean", 1'b0, 3'd0, 6'h00, 8'h00, 8'd0);
      setFault(1'b1, 6'h2A, 8'h01, 8'h00);
      runCheck("bit0sa1", 1'b1, 3'd1, 6'h2A, 8'h01, 8'd3);
      setFault(1'b1, 6'h3F, 8'h00, 8'h80);
      runCheck("bit7sa0", 1'b1, 3'd2, 6'h3F, 8'h80, 8'd2);
      heldStart();
      midReset();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
